// File: rtl/cpu_bus.sv
// cpu_bus: decodes CPU memory-port accesses, serves mirrored 2 KiB work RAM locally
// and forwards every other region over one req/ack port with timeout and open-bus fallback.
module cpu_bus #(
    parameter int unsigned EXT_TIMEOUT = 64
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic [15:0] cpu_address_i,
    input  logic        cpu_read_i,
    input  logic        cpu_write_i,
    input  logic [7:0]  cpu_data_i,
    output logic [7:0]  cpu_data_o,
    output logic        cpu_data_valid_o,
    output logic        ext_req_o,
    output logic        ext_we_o,
    output logic [1:0]  ext_sel_o,
    output logic [15:0] ext_addr_o,
    output logic [7:0]  ext_wdata_o,
    input  logic [7:0]  ext_rdata_i,
    input  logic        ext_ack_i,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAM  = 2'd1,
        ST_EXT  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(EXT_TIMEOUT - 1);

    function automatic logic is_ram_f(input logic [15:0] a);
        return (a < 16'h2000);
    endfunction

    function automatic logic [1:0] sel_f(input logic [15:0] a);
        logic [1:0] sel;
        if (a < 16'h4000) begin
            sel = 2'd0;
        end else if (a < 16'h4020) begin
            sel = 2'd1;
        end else begin
            sel = 2'd2;
        end
        return sel;
    endfunction

    // PPU registers repeat every 8 bytes across 0x2000-0x3FFF
    function automatic logic [15:0] ext_addr_f(input logic [15:0] a);
        logic [15:0] ea;
        if (a < 16'h4000) begin
            ea = {13'h0400, a[2:0]};
        end else begin
            ea = a;
        end
        return ea;
    endfunction

    state_t      state_q, state_d;
    logic [25:0] t_s, s_q, s_d;
    logic        active_s, match_s, start_s;
    logic        s_wr_s;
    logic [15:0] s_addr_s;
    logic [7:0]  s_data_s;
    logic        done_q, done_d;
    logic        stale_q, stale_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  open_bus_q, open_bus_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [1:0]  sel_q, sel_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        timeout_q, timeout_d;
    logic [7:0]  ram_q [0:2047];
    logic [7:0]  ram_rdata_s;
    logic        ram_we_s;

    assign t_s      = {cpu_read_i, cpu_write_i, cpu_address_i, cpu_data_i};
    assign active_s = cpu_read_i | cpu_write_i;
    assign match_s  = (t_s == s_q);
    // stale_q marks an in-flight tuple the CPU moved away from, so it must be reissued
    assign start_s  = active_s & (~match_s | stale_q);
    assign s_wr_s   = s_q[24];
    assign s_addr_s = s_q[23:8];
    assign s_data_s = s_q[7:0];

    assign ram_rdata_s = ram_q[s_addr_s[10:0]];
    assign ram_we_s    = (state_q == ST_RAM) & s_wr_s;

    assign cpu_data_o       = data_q;
    assign cpu_data_valid_o = done_q & match_s & active_s;
    assign ext_req_o        = req_q;
    assign ext_we_o         = we_q;
    assign ext_sel_o        = sel_q;
    assign ext_addr_o       = addr_q;
    assign ext_wdata_o      = wdata_q;
    assign timeout_o        = timeout_q;

    // State register
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d = is_ram_f(cpu_address_i) ? ST_RAM : ST_EXT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RAM:  state_d = ST_DONE;
            ST_EXT: begin
                if (req_q && (ext_ack_i || (tmo_q == TMO_LAST))) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_EXT;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next-state logic
    always_comb begin
        s_d        = s_q;
        done_d     = done_q;
        stale_d    = stale_q;
        tmo_d      = tmo_q;
        data_d     = data_q;
        open_bus_d = open_bus_q;
        req_d      = req_q;
        we_d       = we_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        timeout_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tmo_d = 8'd0;
                req_d = 1'b0;
                if (start_s) begin
                    s_d     = t_s;
                    done_d  = 1'b0;
                    stale_d = 1'b0;
                end else if (!active_s) begin
                    s_d     = 26'd0;
                    done_d  = 1'b0;
                    stale_d = 1'b0;
                end else begin
                    s_d = s_q;
                end
            end
            ST_RAM: begin
                stale_d = stale_q | ~match_s;
                if (s_wr_s) begin
                    open_bus_d = s_data_s;
                end else begin
                    data_d     = ram_rdata_s;
                    open_bus_d = ram_rdata_s;
                end
            end
            ST_EXT: begin
                stale_d = stale_q | ~match_s;
                if (!req_q) begin
                    req_d   = 1'b1;
                    we_d    = s_wr_s;
                    sel_d   = sel_f(s_addr_s);
                    addr_d  = ext_addr_f(s_addr_s);
                    wdata_d = s_data_s;
                    tmo_d   = 8'd0;
                end else if (ext_ack_i) begin
                    req_d = 1'b0;
                    if (s_wr_s) begin
                        open_bus_d = s_data_s;
                    end else begin
                        data_d     = ext_rdata_i;
                        open_bus_d = ext_rdata_i;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    req_d     = 1'b0;
                    timeout_d = 1'b1;
                    if (s_wr_s) begin
                        open_bus_d = s_data_s;
                    end else begin
                        data_d = open_bus_q;
                    end
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            ST_DONE: begin
                stale_d = stale_q | ~match_s;
                done_d  = match_s & ~stale_q;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s_q        <= 26'd0;
            done_q     <= 1'b0;
            stale_q    <= 1'b0;
            tmo_q      <= 8'd0;
            data_q     <= 8'd0;
            open_bus_q <= 8'd0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= 2'd0;
            addr_q     <= 16'd0;
            wdata_q    <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            s_q        <= s_d;
            done_q     <= done_d;
            stale_q    <= stale_d;
            tmo_q      <= tmo_d;
            data_q     <= data_d;
            open_bus_q <= open_bus_d;
            req_q      <= req_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            timeout_q  <= timeout_d;
        end
    end

    // Work RAM keeps its contents through reset
    always_ff @(posedge clock_i) begin
        if (ram_we_s) begin
            ram_q[s_addr_s[10:0]] <= s_data_s;
        end
    end

endmodule
